// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the program-ROM address, queues {pc, word} pairs in a small
// prefetch buffer and hands them to decode over valid/ready. Optional bound check: IFETCH_BOUND_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ROM_WORDS = 100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fault
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (!(DEPTH == 2 || DEPTH == 4) || ROM_WORDS == 0) begin : g_bad_cfg
        $error("instr_fetch: DEPTH must be 2 or 4 and ROM_WORDS nonzero");
    end

    logic [31:0]     fetch_pc_q;
    logic [31:0]     buf_pc_q   [DEPTH];
    logic [31:0]     buf_word_q [DEPTH];
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    logic            fault_q;

    logic pop;
    logic push;
    logic has_space;
    logic fetch_en;
    logic bound_fault;

`ifdef IFETCH_BOUND_EN
    localparam logic [32:0] Bound = 33'(ROM_WORDS) << 2;

    logic halted_q;
    logic in_range;

    assign in_range = ({1'b0, fetch_pc_q} < Bound);
    assign fetch_en = in_range;
    // Pulse only on the first suppressed cycle; halted_q remembers we already reported it.
    assign bound_fault = !redirect_valid && !in_range && !halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= !in_range;
        end
    end
`else
    assign fetch_en    = 1'b1;
    assign bound_fault = 1'b0;
`endif

    assign pop       = instr_valid && instr_ready;
    assign has_space = (count_q < CntW'(DEPTH)) || pop;
    assign push      = !redirect_valid && has_space && fetch_en;

    assign rom_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = buf_word_q[head_q];
    assign instr_pc    = buf_pc_q[head_q];
    assign fault       = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_word_q[i] <= '0;
            end
        end else begin
            fault_q <= (redirect_valid && (redirect_pc[1:0] != 2'b00)) || bound_fault;
            if (redirect_valid) begin
                // Flush; a concurrent pop was already consumed by the decoder this cycle.
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    buf_pc_q[tail_q]   <= fetch_pc_q;
                    buf_word_q[tail_q] <= rom_data;
                    tail_q             <= tail_q + PtrW'(1);
                    fetch_pc_q         <= fetch_pc_q + 32'd4;
                end
                if (pop) begin
                    head_q <= head_q + PtrW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CntW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CntW'(1);
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator on the program-ROM read port. It drives a byte address, captures the returned 32-bit word in the same cycle, and queues fetched instructions with their PCs in a small prefetch buffer. The buffer presents them to the decode stage over a valid/ready handshake. It sits between the program ROM and the decoder and accepts PC redirects from the branch/jump unit.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `DEPTH`, default 2: prefetch buffer entries; legal values are 2 and 4.
- `ROM_WORDS`, default 100: ROM size in 32-bit words; used only when `IFETCH_BOUND_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_addr` out 32: byte address to the program ROM; equals the fetch PC.
- `rom_data` in 32: ROM read data, combinational from `rom_addr` in the same cycle.
- `redirect_valid` in 1: a new PC is requested this cycle.
- `redirect_pc` in 32: target byte address.
- `instr_valid` out 1: buffer head is valid.
- `instr_ready` in 1: decoder accepts the head.
- `instr_data` out 32: head instruction word.
- `instr_pc` out 32: byte address of the head instruction.
- `fault` out 1: one-cycle pulse on a misaligned redirect, or on a bound violation when bounds checking is compiled in.

## Operation

- **State:** `fetch_pc` (32 bits), a circular buffer of `DEPTH` entries of {pc, word}, head and tail pointers, and an occupancy count of width clog2(`DEPTH`)+1.
- **Address output:** `rom_addr` = `fetch_pc` combinationally, every cycle, including cycles with no fetch.
- **pop:** `instr_valid & instr_ready`. Removes the head entry.
- **push:** `!redirect_valid & (count < DEPTH | pop)`.
  - Writes {`fetch_pc`, `rom_data`} at the tail.
  - `fetch_pc` <= `fetch_pc` + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Push and pop in the same cycle:** count is unchanged. A full buffer with pop stays full and admits the new word.
- **Redirect (highest priority):**
  - Flushes all entries, so count becomes 0 and `instr_valid` = 0 next cycle.
  - Loads `fetch_pc` <= {`redirect_pc`[31:2], 2'b00}; no push occurs that cycle.
  - A pop in the same cycle is still a legal handshake. The decoder consumes the head, and the flush discards the rest.
- **Misaligned redirect:** if `redirect_pc`[1:0] != 0, `fault` = 1 on the next cycle, for one cycle. The aligned address is used.
- **Outputs:** `instr_valid` = (count != 0). `instr_data`/`instr_pc` show the head entry. They hold value, not X, when `instr_valid` = 0.
- **Handshake rule:** while `instr_valid` = 1 and `instr_ready` = 0, the head must stay stable until accepted or flushed.
- **Reset values:**
  - Internal: `fetch_pc` = `RESET_PC`, count = 0, pointers = 0.
  - Outputs: `rom_addr` = `RESET_PC`, `instr_valid` = 0, `instr_data` = 0, `instr_pc` = 0, `fault` = 0.
- **Reset mid-operation:** `rst` overrides redirect, push and pop. All entries are discarded.

## Timing

- Fetch latency is one cycle: a word pushed at edge N is visible on `instr_data` after edge N.
- Throughput is one instruction per cycle with `instr_ready` held at 1.
- After `rst` falls:
  - Cycle 0 fetches `RESET_PC`.
  - Cycle 1 shows `instr_valid` = 1, `instr_pc` = `RESET_PC`.
- Redirect penalty: redirect at edge N → target fetched at edge N+1 → valid after N+1.
- `fault` is a registered output.

## Configuration

- Macro: `IFETCH_BOUND_EN`.
- **Defined:**
  - Pushes are suppressed while `fetch_pc` >= `ROM_WORDS`*4.
  - A one-cycle `fault` pulse is raised on the first suppressed cycle after entering that region.
  - Fetching stays halted, with buffer contents draining normally, until a redirect to an in-range address.
- **Undefined:** no bound logic is present; fetch addresses wrap freely over 2^32. `ROM_WORDS` is ignored.

## Test plan

- **Reset and stream:** `RESET_PC`=0 with the ROM model loaded with words W0..W3, `instr_ready`=1 → `instr_pc` reads 0, 4, 8, 12 on consecutive cycles, with `instr_data` = W0..W3 and no bubbles.
- **Backpressure:** `instr_ready`=0 for 5 cycles, `DEPTH`=2 → `fetch_pc` advances exactly 2 words and then holds. The head stays `instr_pc`=0. On release, 0, 4, 8 are delivered in order with no loss or duplication.
- **Redirect:** during streaming, `redirect_valid`=1 with `redirect_pc`=0x1C while the head is 0x8 → next cycle `instr_valid`=0, then `instr_pc`=0x1C. Entries 0xC and 0x10 are never presented.
- **Misaligned redirect:** `redirect_pc`=0x2A → `fault` pulses one cycle and the next delivered `instr_pc`=0x28.
- **Wrap:** redirect to 0xFFFF_FFFC (`IFETCH_BOUND_EN` undefined) → `instr_pc` reads 0xFFFF_FFFC, then 0x0000_0000.
- **Bound (with `IFETCH_BOUND_EN`, `ROM_WORDS`=100):** redirect to 0x18C → 0x18C is delivered, then one `fault` pulse, then `instr_valid`=0 indefinitely. A redirect to 0 resumes fetching at `instr_pc`=0.
